// File: rtl/sync_time_rx.sv
// rtl/sync_time_rx.sv - oversampled serial sync-time receiver with loadable seconds counter
//
// Receives UART-style characters on rx_in, assembles a header-framed
// time word and loads it into a free-running seconds counter.
//
// Ports:
//   clk_10M      sole clock
//   rst          synchronous active-high reset
//   rx_in        asynchronous serial line, idle high
//   rx_busy      high while a character is in progress
//   byte_valid   one-cycle pulse per good character
//   byte_data    last good character
//   syn_set      one-cycle pulse when a complete frame is accepted
//   syn_time     last accepted time word
//   time_second  running seconds count
//   sec_tick     one-cycle pulse on each seconds increment
//   frame_err    one-cycle pulse on parity, stop or timeout error
module sync_time_rx #(
  parameter int                CLKS_PER_BIT  = 16,
  parameter int                DATA_W        = 8,
  parameter int                FRAME_BYTES   = 2,
  parameter logic [DATA_W-1:0] HEADER        = 8'hA5,
  parameter bit                PARITY_EN     = 1'b0,
  parameter int                TIMEOUT_BITS  = 20,
  parameter int                TICKS_PER_SEC = 10_000_000,
  localparam int               TIME_W        = DATA_W * FRAME_BYTES
) (
  input  logic              clk_10M,
  input  logic              rst,
  input  logic              rx_in,
  output logic              rx_busy,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              syn_set,
  output logic [TIME_W-1:0] syn_time,
  output logic [TIME_W-1:0] time_second,
  output logic              sec_tick,
  output logic              frame_err
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int BIT_W   = $clog2(DATA_W + 1);
  localparam int IDX_W   = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int GAP_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = $clog2(GAP_LIM + 1);
  localparam int SUB_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} char_state_t;
  typedef enum logic {F_HUNT, F_COLLECT} frame_state_t;

  char_state_t       state, state_n;
  frame_state_t      fstate, fstate_n;
  logic              rx_m, rx_s, rx_prev;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_err;
  logic [IDX_W-1:0]  idx;
  logic [TIME_W-1:0] asm_q, asm_next;
  logic [GAP_W-1:0]  gap;
  logic [SUB_W-1:0]  sub_q;

  logic fall, cnt_zero, char_ok, char_err, timeout, frame_done, wrap;

  assign fall     = rx_prev & ~rx_s;
  assign cnt_zero = (cnt == '0);
  assign rx_busy  = (state != S_IDLE);
  assign timeout  = (fstate == F_COLLECT) && !rx_busy && (gap == GAP_W'(GAP_LIM));
  assign wrap     = (sub_q == SUB_W'(TICKS_PER_SEC - 1));

  // Character FSM: next state and the stop-sample verdict.
  always_comb begin
    state_n  = state;
    char_ok  = 1'b0;
    char_err = 1'b0;
    case (state)
      S_IDLE:   if (fall) state_n = S_START;
      S_START:  if (cnt_zero) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (cnt_zero && bit_cnt == BIT_W'(DATA_W - 1))
                  state_n = PARITY_EN ? S_PARITY : S_STOP;
      S_PARITY: if (cnt_zero) state_n = S_STOP;
      S_STOP: begin
        if (cnt_zero) begin
          state_n = S_IDLE;
          if (rx_s && !par_err) char_ok  = 1'b1;
          else                  char_err = 1'b1;
        end
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Frame FSM. The final byte is merged combinationally so the load
  // lands on the same edge as its byte_valid.
  always_comb begin
    fstate_n   = fstate;
    frame_done = 1'b0;
    asm_next   = asm_q;
    asm_next[idx*DATA_W +: DATA_W] = shreg;
    case (fstate)
      F_HUNT: if (char_ok && shreg == HEADER) fstate_n = F_COLLECT;
      F_COLLECT: begin
        if (char_err || timeout) begin
          fstate_n = F_HUNT;
        end else if (char_ok && idx == IDX_W'(FRAME_BYTES - 1)) begin
          fstate_n   = F_HUNT;
          frame_done = 1'b1;
        end
      end
      default: fstate_n = F_HUNT;
    endcase
  end

  always_ff @(posedge clk_10M) begin
    if (rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= S_IDLE;
      fstate      <= F_HUNT;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_err     <= 1'b0;
      idx         <= '0;
      asm_q       <= '0;
      gap         <= '0;
      sub_q       <= '0;
      byte_valid  <= 1'b0;
      byte_data   <= '0;
      syn_set     <= 1'b0;
      syn_time    <= '0;
      time_second <= '0;
      sec_tick    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      rx_m    <= rx_in;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
      state   <= state_n;
      fstate  <= fstate_n;

      // Half-bit delay to the start sample, then full bit periods.
      if (state == S_IDLE)
        cnt <= CNT_W'(CLKS_PER_BIT / 2 - 1);
      else
        cnt <= cnt_zero ? CNT_W'(CLKS_PER_BIT - 1) : cnt - 1'b1;

      case (state)
        S_START: begin
          bit_cnt <= '0;
          par_err <= 1'b0;
        end
        S_DATA: if (cnt_zero) begin
          shreg   <= {rx_s, shreg[DATA_W-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        S_PARITY: if (cnt_zero) par_err <= ^{shreg, rx_s};
        default: ;
      endcase

      if (fstate == F_HUNT) begin
        idx   <= '0;
        asm_q <= '0;
      end else if (char_ok) begin
        idx   <= idx + 1'b1;
        asm_q <= asm_next;
      end

      // Idle gap inside a frame; any character activity restarts it.
      if (fstate != F_COLLECT || rx_busy) gap <= '0;
      else                                gap <= gap + 1'b1;

      byte_valid <= char_ok;
      if (char_ok) byte_data <= shreg;
      frame_err  <= char_err | timeout;
      syn_set    <= frame_done;
      if (frame_done) syn_time <= asm_next;

      // A frame load takes priority over a coincident wrap.
      if (frame_done) begin
        time_second <= asm_next;
        sub_q       <= '0;
        sec_tick    <= 1'b0;
      end else if (wrap) begin
        time_second <= time_second + 1'b1;
        sub_q       <= '0;
        sec_tick    <= 1'b1;
      end else begin
        sub_q       <= sub_q + 1'b1;
        sec_tick    <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sync_time_rx.md
# sync_time_rx

Parametrised serial sync-time receiver for the acoustic localisation node. It oversamples an asynchronous UART-style line and assembles a header-framed multi-byte time word. On a valid frame it loads the word into a free-running seconds counter, which then advances on a programmable tick. It replaces the fixed 8-bit, single-byte receiver and adds optional parity, multi-byte frames, inter-byte timeout and error reporting.

## Interface
Parameters:
- CLKS_PER_BIT, 16: clk_10M cycles per serial bit. Must be ≥ 4 and even.
- DATA_W, 8: data bits per character, sent LSB first.
- FRAME_BYTES, 2: time bytes following the header. TIME_W = DATA_W*FRAME_BYTES.
- HEADER, 8'hA5: frame header character, DATA_W bits wide.
- PARITY_EN, 0: 1 = one even-parity bit follows the data bits.
- TIMEOUT_BITS, 20: maximum idle gap inside a frame, in bit times.
- TICKS_PER_SEC, 10_000_000: clk_10M cycles per second increment.

Ports:
- clk_10M, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- rx_in, input, 1: asynchronous serial line, idle high.
- rx_busy, output, 1: high while a character is being received.
- byte_valid, output, 1: one-cycle pulse for each correctly received character.
- byte_data, output, DATA_W: last good character. Held until the next byte_valid.
- syn_set, output, 1: one-cycle pulse when a complete valid frame is accepted.
- syn_time, output, TIME_W: last accepted time word.
- time_second, output, TIME_W: running seconds count.
- sec_tick, output, 1: one-cycle pulse on each seconds increment.
- frame_err, output, 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
- rx_in passes through a 2-flop synchroniser (rx_s). A falling edge is detected on rx_s against its previous value.
- Character FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge, load the bit counter and go to START.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If rx_s = 1, this is a false start: return to IDLE with no pulse. If rx_s = 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. Shift right into the shift register (LSB first). After DATA_W samples, go to PARITY if PARITY_EN = 1, otherwise to STOP.
  - PARITY: sample one bit. Error if XOR(data, parity bit) ≠ 0.
  - STOP: sample one bit. It must be 1, and any parity check must have passed. If so, pulse byte_valid and update byte_data. Otherwise pulse frame_err. Both cases return to IDLE.
- rx_busy = (state ≠ IDLE).
- Frame FSM states: HUNT, COLLECT.
  - HUNT: on a good character equal to HEADER, go to COLLECT with byte index 0. Other good characters are dropped silently, with no error.
  - COLLECT: each good character is written to the assembly register at bits [idx*DATA_W +: DATA_W], so the first byte is least significant. When idx reaches FRAME_BYTES−1, the character completes the frame:
    - syn_time ← assembled word, syn_set pulses for one cycle.
    - time_second ← assembled word, and the sub-second counter clears.
    - Return to HUNT.
  - A character error in COLLECT pulses frame_err, discards the partial frame and returns to HUNT.
  - A HEADER value arriving in COLLECT is data, not a resync.
- Timeout: a gap counter runs while in COLLECT and rx_busy = 0. It clears at the start of each character. When it reaches TIMEOUT_BITS*CLKS_PER_BIT, pulse frame_err and return to HUNT.
- Seconds counter:
  - The sub-second counter counts 0 … TICKS_PER_SEC−1 and then wraps.
  - On the wrap, time_second increments modulo 2^TIME_W and sec_tick pulses.
  - If a load (syn_set) and a wrap fall in the same cycle, the load wins: time_second = new word, sec_tick = 0, sub-second counter = 0.

## Timing
- Reset: all outputs are 0. Both FSMs go to IDLE/HUNT, all counters clear, and the synchroniser flops are set to 1.
- Sample points are relative to the cycle the falling edge is seen on rx_s:
  - Start sample: +CLKS_PER_BIT/2.
  - Data bit k: +CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT.
  - The parity and stop bits follow on the same spacing.
- byte_valid, frame_err and byte_data update one cycle after the stop sample. Latency from the rx_in edge is 2 extra cycles (synchroniser).
- syn_set and the time_second load take effect in the same cycle as the final byte_valid. No extra latency.
- A rst asserted mid-character or mid-frame aborts both immediately. No pulse is produced for the aborted work.
- All pulses are exactly one cycle wide. There is no back-pressure and no handshake.

## Test plan
Bench parameters: CLKS_PER_BIT = 16, TICKS_PER_SEC = 100, PARITY_EN = 0 unless stated.
- Send 0xA5, 0x34, 0x12 → three byte_valid pulses, then syn_set with syn_time = time_second = 16'h1234. Then time_second = 16'h1235 after 100 cycles, with a sec_tick.
- A 4-cycle low glitch on idle rx_in → no byte_valid, no frame_err, rx_busy low again within 11 cycles.
- PARITY_EN = 1: send 0xA5 with a bad parity bit → frame_err pulse, no byte_valid, frame FSM stays in HUNT.
- Send 0xA5, 0x34, then idle 20*16 cycles → frame_err pulse. A subsequent 0x12 does not produce syn_set.
- Load time_second = 16'hFFFF, wait 100 cycles → time_second = 16'h0000 with a sec_tick. Also force a frame completion on the tick cycle → load value wins, no sec_tick.
- Assert rst during the data bits of the second time byte → all outputs 0. The next full frame is accepted normally.
